// File: rtl/cdc_pkg.sv
// Shared width helpers for the CDC receiver blocks. No state types live here.
package cdc_pkg;

  // Pointer width for a power-of-two buffer; never narrower than one bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? int'($clog2(depth)) : 1;
  endfunction

  // Occupancy width for cdc_2phase_rx_level_t: must hold the value DEPTH itself.
  function automatic int unsigned level_w(input int unsigned depth);
    return ptr_w(depth) + 1;
  endfunction

endpackage : cdc_pkg

// File: rtl/cdc_2phase_rx_fifo_if.sv
// Handshake bundle for cdc_2phase_rx_fifo: remote req/ack/data plus local valid/ready/data.
// level_o exists only when CDC_2PHASE_RX_LEVEL_EN is defined.
interface cdc_2phase_rx_fifo_if
  import cdc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
);

  localparam int unsigned LW = level_w(DEPTH);

  logic                  async_req_i;
  logic [DATA_WIDTH-1:0] async_data_i;
  logic                  async_ack_o;
  logic                  valid_o;
  logic                  ready_i;
  logic [DATA_WIDTH-1:0] data_o;
`ifdef CDC_2PHASE_RX_LEVEL_EN
  logic [LW-1:0]         level_o;
`endif

`ifdef CDC_2PHASE_RX_LEVEL_EN
  // Remote source and local consumer side.
  modport master (
    output async_req_i, async_data_i, ready_i,
    input  async_ack_o, valid_o, data_o, level_o
  );

  // Receiver side.
  modport slave (
    input  async_req_i, async_data_i, ready_i,
    output async_ack_o, valid_o, data_o, level_o
  );
`else
  // Remote source and local consumer side.
  modport master (
    output async_req_i, async_data_i, ready_i,
    input  async_ack_o, valid_o, data_o
  );

  // Receiver side.
  modport slave (
    input  async_req_i, async_data_i, ready_i,
    output async_ack_o, valid_o, data_o
  );
`endif

endinterface : cdc_2phase_rx_fifo_if

// File: rtl/cdc_sync_sr.sv
// Multi-flop synchroniser chain with synchronous active-high reset.
module cdc_sync_sr #(
  parameter int unsigned STAGES = 3,
  parameter int unsigned WIDTH  = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(STAGES); i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule : cdc_sync_sr

// File: rtl/cdc_2phase_rx_fifo.sv
// Destination side of a 2-phase toggle req/ack link with a DEPTH-entry receive FIFO.
// Each new req toggle is captured and acked immediately unless the FIFO is full,
// so the remote source can run ahead of the local consumer.
// Optional macro CDC_2PHASE_RX_LEVEL_EN adds the level_o occupancy output.
module cdc_2phase_rx_fifo
  import cdc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  cdc_2phase_rx_fifo_if.slave  bus
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned LW = level_w(DEPTH);

  logic                  req_sync;
  logic                  req_seen;
  logic                  ack_q;
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [LW-1:0]         count;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic new_req;
  logic full;
  logic empty;
  logic push;
  logic pop;

  // Bring the remote req toggle into the local domain.
  cdc_sync_sr #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (1)
  ) u_req_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d     (bus.async_req_i),
    .q     (req_sync)
  );

  // Push/pop qualification; full is taken from registered count so a pop at full cannot admit a push the same edge.
  always_comb begin
    new_req = (req_sync != req_seen);
    full    = (count == LW'(DEPTH));
    empty   = (count == '0);
    push    = new_req && !full;
    pop     = !empty && bus.ready_i;
  end

  // Handshake state, pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_seen <= 1'b0;
      ack_q    <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        req_seen <= ~req_seen;
        ack_q    <= ~ack_q;
        wptr     <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Capture the held remote word; storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wptr] <= bus.async_data_i;
    end
  end

  assign bus.async_ack_o = ack_q;
  assign bus.valid_o     = !empty;
  assign bus.data_o      = empty ? '0 : mem[rptr];
`ifdef CDC_2PHASE_RX_LEVEL_EN
  assign bus.level_o     = count;
`endif

endmodule : cdc_2phase_rx_fifo

// File: doc/cdc_2phase_rx_fifo.md
Name: cdc_2phase_rx_fifo

Overview:
- Destination-side receiver for the 2-phase (toggle req/ack) asynchronous handshake, running entirely in the receiving clock domain.
- Synchronises the incoming request toggle, captures the held data word into a DEPTH-entry FIFO, then toggles ack at once.
- The remote source can therefore send the next word before the local consumer drains the current one.
- Successor to the single-register 2-phase destination: parametrised sync depth and buffer depth, decoupled ack, optional level reporting.

Parameters:
- DATA_WIDTH, 32, width of the transported word.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- SYNC_STAGES, 3, flops in the req synchroniser chain; >= 2.

Ports:
- clk_i  in  1  receiving-domain clock.
- rst_i  in  1  reset; synchronous, active-high.
- async_req_i  in  1  request toggle from the remote source; asynchronous to clk_i.
- async_data_i  in  DATA_WIDTH  remote data; held stable by the source from req toggle until it sees ack.
- async_ack_o  out  1  ack toggle back to the source; driven directly from a flop.
- valid_o  out  1  FIFO non-empty.
- ready_i  in  1  consumer accepts the head word when valid_o && ready_i.
- data_o  out  DATA_WIDTH  head-of-FIFO word.
- level_o  out  $clog2(DEPTH)+1  occupancy; present only with CDC_2PHASE_RX_LEVEL_EN.

Behaviour:
- Reset (rst_i high at posedge, synchronous):
  - Clears the sync chain, req_seen, ack, wptr, rptr and count.
  - Outputs after reset: async_ack_o=0, valid_o=0, data_o='0, level_o=0.
  - FIFO storage is not reset.
- Synchroniser: async_req_i passes through SYNC_STAGES flops; the last stage is req_sync.
- New-item detect: new_req = (req_sync != req_seen).
- Push, when new_req && !full, on one edge:
  - mem[wptr] <= async_data_i;
  - req_seen <= ~req_seen;
  - async_ack_o <= ~async_ack_o;
  - wptr increments.
- Push blocked: if new_req && full, there is no capture and no ack. The source stalls, holding req/data, and the push retries each cycle.
- Pop: valid_o && ready_i increments rptr.
- Outputs:
  - valid_o = (count != 0), registered state only.
  - data_o = mem[rptr] when valid_o, else '0.
- Latency:
  - Req toggle sampled at edge t gives a capture at edge t+SYNC_STAGES.
  - valid_o rises the same edge (count becomes 1); data_o is valid from that cycle.
  - Minimum round trip per word in this domain is SYNC_STAGES+1 edges plus source-side sync.
- Pointers and count:
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is $clog2(DEPTH)+1 bits; full = (count == DEPTH); empty = (count == 0).
- Simultaneous push and pop:
  - count unchanged, both pointers advance.
  - When full, push is evaluated on registered full, so push+pop when full pops only; the push lands next cycle.
- Empty with pop: ready_i is ignored when valid_o=0; no underflow.
- Only one new item per req toggle. The protocol guarantees req cannot toggle again before the ack toggles.
- Reset mid-operation: the remote source must be reset in the same reset event, returning req to 0. Otherwise a req at 1 after reset appears as a new item. This is a system requirement; the block does not check it.
- Consumer back-pressure never affects the ack except through full.

Optional Feature:
- Macro: CDC_2PHASE_RX_LEVEL_EN.
- Defined: level_o port exists and equals count, registered, updated on push/pop edges; reset value 0.
- Undefined: level_o port is absent; count is still used internally; behaviour is otherwise identical.

Decomposition:
- Shared package cdc_pkg holds:
  - localparam-style function for pointer width (clog2 wrapper);
  - cdc_2phase_rx_level_t width helper;
  - no state types.
- Sub-module cdc_sync_sr: SYNC_STAGES x WIDTH flop chain with synchronous active-high reset, instanced for the req bit.
- FIFO storage and pointer logic stay inline.

Test Plan:
- Reset then idle:
  - Stimulus: hold rst_i 2 cycles, req=0.
  - Response: ack=0, valid_o=0, data_o=0, level_o=0 for 10 cycles.
- Single transfer:
  - Stimulus: data=0xDEADBEEF, req 0->1 with ready_i=1, SYNC_STAGES=3.
  - Response: ack toggles to 1 and valid_o=1, data_o=0xDEADBEEF exactly 3 edges after first req sample; pop next edge gives valid_o=0.
- Fill to full, DEPTH=4, ready_i=0:
  - Stimulus: source model sends 0x1..0x5.
  - Response: 4 acks, level_o=4; 5th req held with no ack toggle. Raise ready_i: pops 0x1; 0x5 captured the following edge; order out is 0x1..0x5.
- Full with simultaneous pop:
  - Stimulus: at full with 5th req pending, ready_i=1 for one cycle.
  - Response: that edge gives count 3; next edge gives push and count 4; no data loss or duplication.
- Wrap-around:
  - Stimulus: 64 random words, random ready_i and random source delays.
  - Response: scoreboard exact in-order match; pointers wrap 16 times; valid_o never rises on empty pop.
- Reset mid-stream:
  - Stimulus: rst_i asserted with 2 words buffered, source reset simultaneously.
  - Response: next cycle valid_o=0, ack=0, level_o=0; the next transfer works normally.
